// File: rtl/pend_enc64.sv
// -----------------------------------------------------------------------------
// pend_enc64
// Pending-request encoder. Captures a multi-hot request vector and streams the
// index of every set bit, lowest index first, one index per valid/ready
// handshake. The index is formed hierarchically from two levels of 8-to-3
// priority encoders: level 1 encodes each 8-bit group of the pending vector,
// and level 2 picks the lowest non-empty group.
//
// Ports
//   clk       in   1          rising-edge clock
//   rst       in   1          synchronous active-high reset
//   en        in   1          load strobe, honoured only while load_rdy=1
//   x         in   N          request vector captured on load
//   load_rdy  out  1          high while IDLE (a new vector may be loaded)
//   b         out  IDX_W      lowest pending index; 0 while valid=0
//   valid     out  1          b holds a pending index
//   ready     in   1          consumer accepts b on valid&&ready at clk edge
//   pend      out  N          bits captured but not yet delivered
//   count     out  IDX_W+1    number of set bits in pend
//   done      out  1          one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module pend_enc64 #(
  parameter int IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [(1<<IDX_W)-1:0] x,
  output logic                 load_rdy,
  output logic [IDX_W-1:0]     b,
  output logic                 valid,
  input  logic                 ready,
  output logic [(1<<IDX_W)-1:0] pend,
  output logic [IDX_W:0]       count,
  output logic                 done
);

  localparam int N = 1 << IDX_W;
  localparam int G = N / 8;
  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [N-1:0]   BIT0    = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;

  // 8-to-3 priority encoder: {any, index}, bit 0 has highest priority.
  // Scanning downward lets the lowest set bit overwrite any higher one.
  function automatic logic [3:0] enc8(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [IDX_W:0] popcnt(input logic [N-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Level 1: one encoder per 8-bit group. Unused group slots (IDX_W<6) are
  // tied off so the level-2 encoder always sees a full 8-bit vector.
  logic [7:0] grp_any;
  logic [2:0] grp_lo [8];

  for (genvar g = 0; g < 8; g++) begin : g_l1
    if (g < G) begin : g_live
      logic [3:0] e;
      assign e          = enc8(pend[g*8 +: 8]);
      assign grp_any[g] = e[3];
      assign grp_lo[g]  = e[2:0];
    end else begin : g_pad
      assign grp_any[g] = 1'b0;
      assign grp_lo[g]  = 3'd0;
    end
  end

  // Level 2: lowest non-empty group selects which level-1 index to use.
  logic [3:0] top_e;
  logic [2:0] grp_sel;
  logic [5:0] idx_full;

  assign top_e    = enc8(grp_any);
  assign grp_sel  = top_e[2:0];
  assign idx_full = {grp_sel, grp_lo[grp_sel]};

  // b depends only on registered pend/valid, so ready never reaches b/valid.
  assign b = (valid && top_e[3]) ? idx_full[IDX_W-1:0] : '0;

  logic [N-1:0] clr_mask;
  assign clr_mask = BIT0 << b;

  // ---- control / pending-vector register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      count    <= '0;
      valid    <= 1'b0;
      load_rdy <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // An all-zero vector has nothing to deliver and is dropped.
          if (en && (|x)) begin
            pend     <= x;
            count    <= popcnt(x);
            state    <= BUSY;
            valid    <= 1'b1;
            load_rdy <= 1'b0;
          end
        end
        BUSY: begin
          if (ready) begin
            pend  <= pend & ~clr_mask;
            count <= count - CNT_ONE;
            // Last index accepted: return to IDLE. A load can only be taken
            // from IDLE, so bursts are always separated by one idle cycle.
            if (count == CNT_ONE) begin
              state    <= IDLE;
              valid    <= 1'b0;
              load_rdy <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          valid    <= 1'b0;
          load_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pend_enc64.sv
module tb_pend_enc64;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] x;
  logic        load_rdy;
  logic [5:0]  b;
  logic        valid;
  logic        ready;
  logic [63:0] pend;
  logic [6:0]  count;
  logic        done;

  int checks = 0;
  int errors = 0;

  pend_enc64 #(.IDX_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .x        (x),
    .load_rdy (load_rdy),
    .b        (b),
    .valid    (valid),
    .ready    (ready),
    .pend     (pend),
    .count    (count),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] v;
    int          k;
    int          first;
    int          last;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [63:0] v);
    for (int i = 0; i < 64; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Called at a falling edge; returns at the falling edge after the load edge.
  task automatic load(input logic [63:0] v);
    en = 1'b1;
    x  = v;
    @(negedge clk);
    en = 1'b0;
    x  = '0;
  endtask

  task automatic drain(input logic [63:0] v, input bit rnd,
                       output int first_b, output int last_b, output int n);
    logic [63:0] mp;
    int          cyc;
    bit          rd;
    int          lo;
    mp = v;
    cyc = 0;
    n = 0;
    first_b = -1;
    last_b = -1;
    while (mp != 0 && cyc < 2000) begin
      lo = lowest(mp);
      chk("valid_busy", valid, 1);
      chk("b_index", b, lo);
      chk("count_busy", count, $countones(mp));
      chk("pend_busy", pend, mp);
      chk("done_mid", done, 0);
      chk("load_rdy_busy", load_rdy, 0);
      rd = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ready = rd;
      @(negedge clk);
      cyc++;
      if (rd) begin
        if (n == 0) first_b = lo;
        last_b = lo;
        mp[lo] = 1'b0;
        n++;
      end
    end
    if (mp != 0) chk("drain_timeout", mp, 0);
    ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("load_rdy_after", load_rdy, 1);
    chk("valid_after", valid, 0);
    chk("b_idle", b, 0);
    chk("pend_idle", pend, 0);
    chk("count_idle", count, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
  endtask

  initial begin
    int f, l, n;
    logic [63:0] rv;

    tbl[0] = '{64'h1,                     1,  0,  0};
    tbl[1] = '{64'h8000_0000_0000_0012,   3,  1, 63};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF,  64,  0, 63};
    tbl[3] = '{64'h8000_0000_0000_0000,   1, 63, 63};
    tbl[4] = '{64'h0101_0101_0101_0101,   8,  0, 56};
    tbl[5] = '{64'h0000_0000_0000_00F0,   4,  4,  7};

    rst = 1'b1; en = 1'b0; ready = 1'b0; x = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load_rdy", load_rdy, 1);
    chk("rst_valid", valid, 0);
    chk("rst_b", b, 0);
    chk("rst_count", count, 0);
    chk("rst_pend", pend, 0);
    chk("rst_done", done, 0);

    // Directed table, ready held high.
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].v);
      drain(tbl[i].v, 1'b0, f, l, n);
      chk("tbl_k", n, tbl[i].k);
      chk("tbl_first", f, tbl[i].first);
      chk("tbl_last", l, tbl[i].last);
    end

    // Stall with ready low, then drain; try a load on the final handshake edge.
    load(64'h0A);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", valid, 1);
      chk("stall_b", b, 1);
      chk("stall_pend", pend, 64'h0A);
      chk("stall_count", count, 2);
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("stall_b2", b, 3);
    chk("stall_count2", count, 1);
    chk("stall_pend2", pend, 64'h08);
    en = 1'b1;
    x  = 64'h05;
    @(negedge clk);
    en = 1'b0;
    x  = '0;
    ready = 1'b0;
    chk("stall_done", done, 1);
    chk("stall_valid_end", valid, 0);
    chk("gap_pend", pend, 0);
    chk("gap_load_rdy", load_rdy, 1);
    @(negedge clk);
    chk("gap_done_clear", done, 0);
    chk("gap_no_load", valid, 0);

    // en while BUSY is ignored.
    load(64'h0A);
    en = 1'b1;
    x  = 64'hFF;
    @(negedge clk);
    en = 1'b0;
    x  = '0;
    chk("busy_en_pend", pend, 64'h0A);
    chk("busy_en_count", count, 2);
    chk("busy_en_b", b, 1);
    drain(64'h0A, 1'b0, f, l, n);

    // Zero vector in IDLE is dropped.
    en = 1'b1;
    x  = '0;
    @(negedge clk);
    en = 1'b0;
    chk("zero_load_rdy", load_rdy, 1);
    chk("zero_valid", valid, 0);
    chk("zero_done", done, 0);
    chk("zero_pend", pend, 0);
    @(negedge clk);
    chk("zero_done2", done, 0);

    // Reset aborts a burst after 10 handshakes.
    load(64'hFFFF_FFFF_FFFF_FFFF);
    ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_pend", pend, ~64'h3FF);
    chk("abort_count", count, 54);
    chk("abort_b", b, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b0;
    chk("abort_rst_pend", pend, 0);
    chk("abort_rst_count", count, 0);
    chk("abort_rst_valid", valid, 0);
    chk("abort_rst_done", done, 0);
    chk("abort_rst_load_rdy", load_rdy, 1);
    chk("abort_rst_b", b, 0);

    // Random vectors with random backpressure.
    for (int r = 0; r < 20; r++) begin
      rv = {$urandom, $urandom};
      if (r % 2 == 0) rv = rv & {$urandom, $urandom} & {$urandom, $urandom};
      if (rv == 0) rv = 64'h1;
      load(rv);
      drain(rv, 1'b1, f, l, n);
      chk("rand_k", n, $countones(rv));
      chk("rand_first", f, lowest(rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
